muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-004 SHALL have port op  input  1  0 = unsigned multiply, 1 = unsigned divide.
REQ-005 SHALL have port dst  input  3  destination register index for the low result.
REQ-006 SHALL have port opA  input  16  multiplicand or dividend; driven from register-file read port R1.
REQ-007 SHALL have port opB  input  16  multiplier or divisor; driven from register-file read port R2.
REQ-008 SHALL have port busy  output  1  high in every non-IDLE state.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking the final write-back.
REQ-010 SHALL have port dbz  output  1  divide-by-zero flag, valid only while done = 1.
REQ-011 SHALL have port wr  output  1  register-file write enable.
REQ-012 SHALL have port wrAddr  output  3  register-file write address.
REQ-013 SHALL have port wrData  output  16  register-file write data.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, WB_LO and WB_HI.
REQ-015 SHALL accept a request only when state = IDLE and start = 1 at a rising edge.
REQ-016 On accept, SHALL latch opA, opB, op and dst; later changes to these inputs SHALL have no effect until the next accept.
REQ-017 SHALL ignore start while busy = 1; requests are neither queued nor counted.
REQ-018 SHALL move from accept to CALC and stay there exactly 16 cycles, driven by a 4-bit counter running 0..15; the step at count 15 SHALL go to WB_LO.
REQ-019 MUL SHALL use shift-add, one multiplier bit per CALC cycle, to form an unsigned 32-bit product P = opA*opB.
REQ-020 DIV SHALL use restoring division, one quotient bit per CALC cycle, to form unsigned Q = opA/opB and R = opA mod opB.
REQ-021 DIV with latched opB = 0 SHALL skip CALC and go from accept directly to WB_LO, with Q = 16'hFFFF and R = latched opA.
REQ-022 WB_LO SHALL last one cycle with wr = 1, wrAddr = dst, and wrData = P[15:0] for MUL or Q for DIV.
REQ-023 WB_HI SHALL last one cycle with wr = 1, wrAddr = (dst+1) mod 8, and wrData = P[31:16] for MUL or R for DIV.
REQ-024 In WB_HI, done SHALL be 1, and dbz SHALL be 1 only for the divide-by-zero case of REQ-021; the next state SHALL be IDLE.
REQ-025 dst = 7 SHALL wrap the high/remainder write to register 0.
REQ-026 wr SHALL be 0 in IDLE and CALC, and wrAddr and wrData SHALL be 0 whenever wr = 0.
REQ-027 Total latency from the accept edge to the done cycle SHALL be 18 cycles normally and 2 cycles for divide-by-zero.
REQ-028 After returning to IDLE, a new start SHALL be acceptable at the very next edge; there are no dead cycles.
REQ-029 All outputs SHALL be registered or decoded from the state register only, with no combinational path from inputs to outputs.

Reset
REQ-030 rst = 1 at a rising edge SHALL force IDLE and clear the counter, the latched operands and the accumulators, taking priority over start.
REQ-031 While in reset and in the cycle after it, busy, done, dbz, wr, wrAddr and wrData SHALL all be 0.
REQ-032 rst during CALC, WB_LO or WB_HI SHALL abort the operation; any remaining writes SHALL NOT occur and done SHALL NOT pulse.

Verification
REQ-033 MUL, opA = 5, opB = 7, dst = 2 -> busy for 18 cycles; write R2 = 16'h0023, then R3 = 16'h0000 with done = 1 and dbz = 0.
REQ-034 MUL, opA = 16'hFFFF, opB = 16'hFFFF, dst = 7 -> write R7 = 16'h0001, then R0 = 16'hFFFE (address wrap).
REQ-035 DIV, opA = 100, opB = 7, dst = 4 -> write R4 = 16'h000E, then R5 = 16'h0002 with done = 1; total latency 18 cycles.
REQ-036 DIV, opA = 16'h1234, opB = 0, dst = 1 -> write R1 = 16'hFFFF on cycle 1, then R2 = 16'h1234 with done = 1 and dbz = 1 on cycle 2.
REQ-037 start held high throughout a MUL, with opA/opB changed mid-CALC -> exactly one result from the latched operands; the second accept occurs the edge after done.
REQ-038 rst asserted at CALC count 8 -> next cycle busy = 0; no wr pulse is ever observed; a fresh MUL 3*3 then yields 16'h0009 and 16'h0000.

Source files
------------

// File: rtl/muldiv_if.sv
// Request/write-back bundle between the issuing pipeline and the 16-bit multiply/divide unit.
// Master drives start/op/dst/opA/opB; slave returns busy/done/dbz and the two register-file writes.
// No backpressure: requests are only taken while the unit is idle, writes are unconditional.
interface muldiv_if;
    logic        start;
    logic        op;
    logic [2:0]  dst;
    logic [15:0] opA;
    logic [15:0] opB;
    logic        busy;
    logic        done;
    logic        dbz;
    logic        wr;
    logic [2:0]  wrAddr;
    logic [15:0] wrData;

    modport master (
        output start, op, dst, opA, opB,
        input  busy, done, dbz, wr, wrAddr, wrData
    );

    modport slave (
        input  start, op, dst, opA, opB,
        output busy, done, dbz, wr, wrAddr, wrData
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned 16x16 multiply (shift-add) / 16/16 divide (restoring), two register-file writes.
// Latency: accept -> done is 18 cycles, 2 cycles for divide-by-zero; writes low half then high half.
// Backpressure: none; start is only sampled while idle, requests seen while busy are dropped.
// Ports: clk, rst (sync, active-high); bus.slave carries start/op/dst/opA/opB in and
//        busy/done/dbz/wr/wrAddr/wrData out. Outputs depend only on registered state.
module muldiv_unit (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, WB_LO, WB_HI} state_t;

    state_t      state;
    state_t      stateNext;
    logic [3:0]  cnt;
    logic        opR;
    logic        dbzR;
    logic [2:0]  dstR;
    // Multiplicand for MUL, divisor for DIV.
    logic [15:0] operand;
    // MUL: {accHi, accLo} is the partial product with the unconsumed multiplier bits in accLo.
    // DIV: accHi is the running remainder, accLo shifts dividend bits out and quotient bits in.
    logic [15:0] accHi;
    logic [15:0] accLo;

    logic        accept;
    logic        divZero;
    logic [16:0] mulSum;
    logic [16:0] divShift;
    logic        divFits;
    logic [15:0] divRem;

    assign accept  = (state == IDLE) && bus.start;
    assign divZero = bus.op && (bus.opB == 16'h0000);

    assign mulSum   = {1'b0, accHi} + {1'b0, (accLo[0] ? operand : 16'h0000)};
    assign divShift = {accHi, accLo[15]};
    assign divFits  = divShift >= {1'b0, operand};
    // When the trial subtraction fits, the true difference is below the divisor, so 16 bits suffice.
    assign divRem   = divShift[15:0] - operand;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (bus.start) stateNext = divZero ? WB_LO : CALC;
            CALC:    if (cnt == 4'd15) stateNext = WB_LO;
            WB_LO:   stateNext = WB_HI;
            WB_HI:   stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= 4'd0;
            opR     <= 1'b0;
            dbzR    <= 1'b0;
            dstR    <= 3'd0;
            operand <= 16'h0000;
            accHi   <= 16'h0000;
            accLo   <= 16'h0000;
        end else if (accept) begin
            cnt  <= 4'd0;
            opR  <= bus.op;
            dstR <= bus.dst;
            dbzR <= divZero;
            if (divZero) begin
                // Results are final immediately: all-ones quotient, dividend as remainder.
                operand <= bus.opB;
                accHi   <= bus.opA;
                accLo   <= 16'hFFFF;
            end else if (bus.op) begin
                operand <= bus.opB;
                accHi   <= 16'h0000;
                accLo   <= bus.opA;
            end else begin
                operand <= bus.opA;
                accHi   <= 16'h0000;
                accLo   <= bus.opB;
            end
        end else if (state == CALC) begin
            cnt <= cnt + 4'd1;
            if (opR) begin
                accHi <= divFits ? divRem : divShift[15:0];
                accLo <= {accLo[14:0], divFits};
            end else begin
                {accHi, accLo} <= {mulSum, accLo[15:1]};
            end
        end
    end

    always_comb begin
        bus.busy   = (state != IDLE);
        bus.wr     = 1'b0;
        bus.done   = 1'b0;
        bus.dbz    = 1'b0;
        bus.wrAddr = 3'd0;
        bus.wrData = 16'h0000;
        case (state)
            WB_LO: begin
                bus.wr     = 1'b1;
                bus.wrAddr = dstR;
                bus.wrData = accLo;
            end
            WB_HI: begin
                bus.wr     = 1'b1;
                bus.done   = 1'b1;
                bus.dbz    = dbzR;
                bus.wrAddr = dstR + 3'd1;
                bus.wrData = accHi;
            end
            default: ;
        endcase
    end
endmodule
